// File: rtl/rk4_pkg.sv
// rk4_pkg: shared state encoding and default sizes for the RK4 iteration sequencer
package rk4_pkg;
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        WAIT = 2'b01,
        HOLD = 2'b10,
        DONE = 2'b11
    } state_t;
    localparam int W_DEF   = 32;
    localparam int CW_DEF  = 32;
    localparam int LAT_DEF = 5;
    localparam int LCW     = 8;
endpackage

// File: rtl/rk4_lat_timer.sv
// rk4_lat_timer: loadable down-counter with a zero flag for pipeline-wait timing
module rk4_lat_timer import rk4_pkg::*; (
    input  logic           clk,
    input  logic           rst,
    input  logic           load,
    input  logic           dec,
    input  logic [LCW-1:0] load_val,
    output logic           zero
);
    logic [LCW-1:0] cnt;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt <= '0;
        else if (load) cnt <= load_val;
        else if (dec && cnt != '0) cnt <= cnt - 1'b1;
    end
    assign zero = cnt == '0;
endmodule

// File: rtl/rk4_iter_seq.sv
// rk4_iter_seq: owns the (x, y) state, waits out the RK4 datapath latency and
// writes each step result back, counting iterations up to a run-time limit.
module rk4_iter_seq import rk4_pkg::*; #(
    parameter int W   = W_DEF,
    parameter int CW  = CW_DEF,
    parameter int LAT = LAT_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          abort,
    input  logic          step_mode,
    input  logic          step,
    input  logic [W-1:0]  x0,
    input  logic [W-1:0]  y0,
    input  logic [CW-1:0] n_iter,
    output logic [W-1:0]  dp_x_in,
    output logic [W-1:0]  dp_y_in,
    input  logic [W-1:0]  dp_x_out,
    input  logic [W-1:0]  dp_y_out,
    output logic [W-1:0]  x_out,
    output logic [W-1:0]  y_out,
    output logic [CW-1:0] iter_cnt,
    output logic          sample_valid,
    output logic          busy,
    output logic          done,
    output logic          aborted
);
    localparam logic [LCW-1:0] LAT_V = LCW'(LAT);

    state_t state, nxt;
    logic [W-1:0] xr, yr;
    logic [CW-1:0] nr;
    logic mode, zero, ld, cap, last, go;

    rk4_lat_timer u_timer (
        .clk(clk),
        .rst(rst),
        .load(ld),
        .dec(state == WAIT),
        .load_val(LAT_V),
        .zero(zero)
    );

    assign go   = state == IDLE && start && !abort;
    assign last = (iter_cnt + CW'(1)) == nr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else state <= nxt;
    end

    // abort outranks a capture landing on the same edge
    always_comb begin
        nxt = state;
        ld  = 1'b0;
        cap = 1'b0;
        unique case (state)
            IDLE: if (go) begin
                nxt = n_iter == '0 ? DONE : WAIT;
                ld  = n_iter != '0;
            end
            WAIT: if (abort) nxt = IDLE;
            else if (zero) begin
                cap = 1'b1;
                nxt = last ? DONE : (mode ? HOLD : WAIT);
                ld  = !last && !mode;
            end
            HOLD: if (abort) nxt = IDLE;
            else if (step) begin
                nxt = WAIT;
                ld  = 1'b1;
            end
            DONE: nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            xr           <= '0;
            yr           <= '0;
            nr           <= '0;
            mode         <= 1'b0;
            iter_cnt     <= '0;
            sample_valid <= 1'b0;
            aborted      <= 1'b0;
        end else begin
            if (go) begin
                xr       <= x0;
                yr       <= y0;
                nr       <= n_iter;
                mode     <= step_mode;
                iter_cnt <= '0;
            end
            if (cap) begin
                xr       <= dp_x_out;
                yr       <= dp_y_out;
                iter_cnt <= iter_cnt + CW'(1);
            end
            sample_valid <= cap;
            aborted      <= abort && (state == WAIT || state == HOLD);
        end
    end

    assign dp_x_in = xr;
    assign dp_y_in = yr;
    assign x_out   = xr;
    assign y_out   = yr;
    assign busy    = state == WAIT || state == HOLD;
    assign done    = state == DONE;
endmodule

// File: tb/tb_rk4_iter_seq.sv
// tb_rk4_iter_seq: scenario tasks plus a scoreboard for every captured sample,
// driving a 5-stage bench datapath that computes (x+1, y+x).
module tb_rk4_iter_seq;
    localparam int W = 32;
    localparam int CW = 32;
    localparam int LAT = 5;

    typedef struct {
        logic [W-1:0]  x;
        logic [W-1:0]  y;
        logic [CW-1:0] n;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0, abort = 1'b0, step_mode = 1'b0, step = 1'b0;
    logic [W-1:0] x0 = '0, y0 = '0;
    logic [CW-1:0] n_iter = '0;
    logic [W-1:0] dp_x_in, dp_y_in, dp_x_out, dp_y_out, x_out, y_out;
    logic [CW-1:0] iter_cnt;
    logic sample_valid, busy, done, aborted;
    logic [W-1:0] px [LAT];
    logic [W-1:0] py [LAT];
    exp_t exp_q [$];
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    rk4_iter_seq #(.W(W), .CW(CW), .LAT(LAT)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .step_mode(step_mode), .step(step), .x0(x0), .y0(y0), .n_iter(n_iter),
        .dp_x_in(dp_x_in), .dp_y_in(dp_y_in), .dp_x_out(dp_x_out), .dp_y_out(dp_y_out),
        .x_out(x_out), .y_out(y_out), .iter_cnt(iter_cnt),
        .sample_valid(sample_valid), .busy(busy), .done(done), .aborted(aborted)
    );

    always @(posedge clk) begin
        px[0] <= dp_x_in + 1;
        py[0] <= dp_y_in + dp_x_in;
        for (int i = 1; i < LAT; i++) begin
            px[i] <= px[i-1];
            py[i] <= py[i-1];
        end
    end
    assign dp_x_out = px[LAT-1];
    assign dp_y_out = py[LAT-1];

    always @(negedge clk) begin
        if (!rst && sample_valid) begin
            exp_t e;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL sample_unexpected x_out=%0d y_out=%0d iter=%0d", x_out, y_out, iter_cnt);
            end else begin
                e = exp_q.pop_front();
                if (x_out !== e.x || y_out !== e.y || iter_cnt !== e.n) begin
                    errors++;
                    $display("FAIL sample got x=%0d y=%0d n=%0d want x=%0d y=%0d n=%0d",
                             x_out, y_out, iter_cnt, e.x, e.y, e.n);
                end
            end
        end
    end

    function automatic void push_run(input logic [W-1:0] xi, input logic [W-1:0] yi, input int n);
        logic [W-1:0] x = xi, y = yi, ny;
        for (int i = 1; i <= n; i++) begin
            ny = y + x;
            x = x + 1;
            y = ny;
            exp_q.push_back('{x, y, CW'(i)});
        end
    endfunction

    task automatic drive_start(input logic [W-1:0] xi, input logic [W-1:0] yi,
                               input logic [CW-1:0] n, input logic sm);
        @(negedge clk);
        x0 = xi; y0 = yi; n_iter = n; step_mode = sm; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic test_reset;
        repeat (2) @(negedge clk);
        checks++;
        if ({x_out, y_out, dp_x_in, dp_y_in, iter_cnt, sample_valid, busy, done, aborted} !== '0) begin
            errors++;
            $display("FAIL reset_outputs x=%0d y=%0d n=%0d busy=%b done=%b", x_out, y_out, iter_cnt, busy, done);
        end
        rst = 1'b0;
    endtask

    task automatic test_basic;
        push_run(0, 0, 3);
        drive_start(0, 0, 3, 1'b0);
        for (int k = 0; k <= 20; k++) begin
            if (k > 0) @(negedge clk);
            checks++;
            if (busy !== (k < 18) || done !== (k == 18) || sample_valid !== (k == 6 || k == 12 || k == 18)) begin
                errors++;
                $display("FAIL basic_timing k=%0d busy=%b done=%b sv=%b", k, busy, done, sample_valid);
            end
        end
        checks++;
        if (x_out !== 3 || y_out !== 3 || iter_cnt !== 3) begin
            errors++;
            $display("FAIL basic_final x=%0d y=%0d n=%0d want 3 3 3", x_out, y_out, iter_cnt);
        end
    endtask

    task automatic test_zero;
        drive_start(7, 9, 0, 1'b0);
        checks++;
        if (done !== 1'b1 || busy !== 1'b0 || x_out !== 7 || y_out !== 9 || iter_cnt !== 0) begin
            errors++;
            $display("FAIL zero_iter done=%b busy=%b x=%0d y=%0d n=%0d want 1 0 7 9 0", done, busy, x_out, y_out, iter_cnt);
        end
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        checks++;
        if (done !== 1'b0 || aborted !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL zero_after done=%b aborted=%b busy=%b want 0 0 0", done, aborted, busy);
        end
    endtask

    task automatic test_step;
        push_run(0, 0, 2);
        drive_start(0, 0, 2, 1'b1);
        for (int k = 0; k <= 25; k++) begin
            if (k > 0) @(negedge clk);
            checks++;
            if (busy !== 1'b1 || done !== 1'b0) begin
                errors++;
                $display("FAIL step_hold k=%0d busy=%b done=%b want 1 0", k, busy, done);
            end
        end
        checks++;
        if (iter_cnt !== 1) begin
            errors++;
            $display("FAIL step_hold_cnt iter=%0d want 1", iter_cnt);
        end
        step = 1'b1;
        @(negedge clk);
        step = 1'b0;
        for (int k = 0; k <= 8; k++) begin
            if (k > 0) @(negedge clk);
            checks++;
            if (busy !== (k < 6) || done !== (k == 6)) begin
                errors++;
                $display("FAIL step_run k=%0d busy=%b done=%b", k, busy, done);
            end
        end
    endtask

    task automatic test_abort;
        push_run(0, 0, 1);
        drive_start(0, 0, 4, 1'b0);
        repeat (8) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        checks++;
        if (aborted !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || x_out !== 1 || iter_cnt !== 1) begin
            errors++;
            $display("FAIL abort_pulse aborted=%b busy=%b done=%b x=%0d n=%0d want 1 0 0 1 1",
                     aborted, busy, done, x_out, iter_cnt);
        end
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            checks++;
            if (aborted !== 1'b0 || done !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL abort_after k=%0d aborted=%b done=%b busy=%b", k, aborted, done, busy);
            end
        end
        push_run(10, 5, 1);
        drive_start(10, 5, 1, 1'b0);
        for (int k = 0; k <= 7; k++) begin
            if (k > 0) @(negedge clk);
            checks++;
            if (done !== (k == 6)) begin
                errors++;
                $display("FAIL rerun_done k=%0d done=%b", k, done);
            end
        end
        checks++;
        if (x_out !== 11 || y_out !== 15) begin
            errors++;
            $display("FAIL rerun_final x=%0d y=%0d want 11 15", x_out, y_out);
        end
    endtask

    task automatic test_async_reset;
        push_run(5, 6, 3);
        drive_start(5, 6, 3, 1'b0);
        repeat (2) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({x_out, y_out, dp_x_in, dp_y_in, iter_cnt, busy, done, sample_valid, aborted} !== '0) begin
            errors++;
            $display("FAIL async_reset x=%0d y=%0d n=%0d busy=%b", x_out, y_out, iter_cnt, busy);
        end
        exp_q.delete();
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            checks++;
            if (sample_valid !== 1'b0 || done !== 1'b0 || aborted !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL post_reset k=%0d sv=%b done=%b aborted=%b busy=%b", k, sample_valid, done, aborted, busy);
            end
        end
        x0 = 33; n_iter = 1; start = 1'b1; abort = 1'b1;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        for (int k = 0; k < 8; k++) begin
            checks++;
            if (busy !== 1'b0 || done !== 1'b0 || aborted !== 1'b0 || x_out !== 0) begin
                errors++;
                $display("FAIL start_abort k=%0d busy=%b done=%b aborted=%b x=%0d", k, busy, done, aborted, x_out);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_back_to_back;
        logic [W-1:0] hold_x;
        push_run(0, 0, 2);
        push_run(0, 0, 2);
        @(negedge clk);
        x0 = 0; y0 = 0; n_iter = 2; step_mode = 1'b0; start = 1'b1;
        @(negedge clk);
        hold_x = dp_x_in;
        for (int k = 0; k <= 27; k++) begin
            if (k > 0) @(negedge clk);
            checks++;
            if (busy !== ((k < 12) || (k >= 14 && k < 26)) || done !== (k == 12 || k == 26)) begin
                errors++;
                $display("FAIL b2b_timing k=%0d busy=%b done=%b", k, busy, done);
            end
            if (k == 0 || k == 6) begin
                hold_x = dp_x_in;
                checks++;
                if (dp_x_in !== W'(k / 6)) begin
                    errors++;
                    $display("FAIL b2b_dp_value k=%0d dp_x_in=%0d want %0d", k, dp_x_in, k / 6);
                end
            end else if (k < 12) begin
                checks++;
                if (dp_x_in !== hold_x) begin
                    errors++;
                    $display("FAIL b2b_dp_stable k=%0d dp_x_in=%0d want %0d", k, dp_x_in, hold_x);
                end
            end
            if (k == 14) start = 1'b0;
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_zero();
        test_step();
        test_abort();
        test_async_reset();
        test_back_to_back();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_leftover remaining=%0d want 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
